// File: rtl/serial_sub_16_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_16_pkg
// Shared definitions for the bit-serial subtractor:
//   SUB_WIDTH  - default operand/result width
//   SUB_CNT_W  - bit-counter width for the default width
//   state_t    - controller states (IDLE, SHIFT)
// ---------------------------------------------------------------------------
package serial_sub_16_pkg;

    localparam int SUB_WIDTH = 16;
    localparam int SUB_CNT_W = $clog2(SUB_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : serial_sub_16_pkg

// File: rtl/serial_sub_16_if.sv
// ---------------------------------------------------------------------------
// serial_sub_16_if
// Start/done handshake and operand/result bus of the serial subtractor.
//   start, a, b, bin       - request side (driven by the master)
//   busy, done, diff, bout - status/result side (driven by the subtractor)
// ---------------------------------------------------------------------------
interface serial_sub_16_if
    import serial_sub_16_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );

endinterface : serial_sub_16_if

// File: rtl/serial_sub_16_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// Combinational 1-bit subtractor cell: computes ai - bi - br.
//   i_ai      - minuend bit
//   i_bi      - subtrahend bit
//   i_br      - borrow in
//   o_d       - difference bit
//   o_br_next - borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic i_ai,
    input  logic i_bi,
    input  logic i_br,
    output logic o_d,
    output logic o_br_next
);

    logic w_axb;

    assign w_axb     = i_ai ^ i_bi;
    assign o_d       = w_axb ^ i_br;
    // Borrow when bi exceeds ai, or when the bits are equal and a borrow ripples in.
    assign o_br_next = (~i_ai & i_bi) | (~w_axb & i_br);

endmodule : full_subtractor

// File: rtl/serial_sub_16.sv
// ---------------------------------------------------------------------------
// serial_sub_16
// Bit-serial unsigned subtractor, LSB first: diff = a - b - bin, bout = borrow.
// One bit per clock; result appears WIDTH cycles after the accepted start and
// is held until the next operation completes.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of serial_sub_16_if (start/a/b/bin in,
//           busy/done/diff/bout out, all outputs registered)
// ---------------------------------------------------------------------------
module serial_sub_16
    import serial_sub_16_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_sub_16_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_fs (
        .i_ai      (r_a[0]),
        .i_bi      (r_b[0]),
        .i_br      (r_br),
        .o_d       (w_d),
        .o_br_next (w_br_next)
    );

    // Result register fills from the MSB so that after WIDTH steps bit 0 sits at the LSB.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    // Controller and datapath: capture on start, one bit-step per SHIFT cycle, publish at the end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;

endmodule : serial_sub_16

// File: tb/tb_serial_sub_16.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_16
// Directed self-checking bench for serial_sub_16 with hand-computed vectors.
// ---------------------------------------------------------------------------
module tb_serial_sub_16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_sub_16_if #(.WIDTH(16)) bus ();

    serial_sub_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single operation: start accepted at edge k, optional ignored start at k+5.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic binv, input logic [15:0] ed, input logic eb,
                          input logic [15:0] prev_diff, input bit inject);
        int bad_mid;
        bad_mid   = 0;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = binv;
        bus.start = 1'b1;
        tick();                                   // edge k
        bus.start = 1'b0;
        chk({tag, "_busy_k"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            tick();                               // edge k+i
            if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.diff !== prev_diff)
                bad_mid++;
            if (inject && i == 4) begin
                bus.start = 1'b1;
                bus.a     = 16'h1234;
                bus.b     = 16'h0001;
                bus.bin   = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk({tag, "_mid_bad_cycles"}, 32'(bad_mid), 32'd0);
        tick();                                   // edge k+16
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        tick();                                   // edge k+17
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int seen_done;
        checks    = 0;
        failures  = 0;
        seen_done = 0;

        // Reset held with start asserted: nothing accepted.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 16'h001F;
        bus.b     = 16'h000C;
        bus.bin   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'h0000);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        run_op("basic",   16'h001F, 16'h000C, 1'b0, 16'h0013, 1'b0, 16'h0000, 1'b0);
        run_op("under1",  16'h000C, 16'h001F, 1'b0, 16'hFFED, 1'b1, 16'h0013, 1'b0);
        run_op("under2",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 16'hFFED, 1'b0);
        run_op("binonly", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'hFFFF, 1'b0);
        run_op("ignore",  16'h001F, 16'h000C, 1'b0, 16'h0013, 1'b0, 16'hFFFE, 1'b1);

        // Abort: reset at edge k+8.
        bus.a     = 16'h00F0;
        bus.b     = 16'h000F;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        tick();                                   // edge k
        bus.start = 1'b0;
        for (int i = 1; i <= 7; i++) tick();      // through edge k+7
        rst_n = 1'b0;
        tick();                                   // edge k+8
        rst_n = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'h0000);
        chk("abort_bout", 32'(bus.bout), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);

        // Back-to-back with start held high.
        bus.a     = 16'hC61F;
        bus.b     = 16'h018C;
        bus.bin   = 1'b1;
        bus.start = 1'b1;
        tick();                                   // edge k
        bus.a     = 16'h0001;
        bus.b     = 16'h0002;
        bus.bin   = 1'b0;
        for (int i = 1; i <= 16; i++) tick();     // through edge k+16
        chk("b2b1_done", 32'(bus.done), 32'd1);
        chk("b2b1_diff", 32'(bus.diff), 32'hC492);
        chk("b2b1_bout", 32'(bus.bout), 32'd0);
        chk("b2b1_busy", 32'(bus.busy), 32'd0);
        tick();                                   // edge k+17: second accepted
        bus.start = 1'b0;
        chk("b2b2_busy", 32'(bus.busy), 32'd1);
        chk("b2b2_done_low", 32'(bus.done), 32'd0);
        chk("b2b2_hold", 32'(bus.diff), 32'hC492);
        for (int i = 18; i <= 33; i++) tick();    // through edge k+33
        chk("b2b2_done", 32'(bus.done), 32'd1);
        chk("b2b2_diff", 32'(bus.diff), 32'hFFFF);
        chk("b2b2_bout", 32'(bus.bout), 32'd1);
        tick();
        chk("b2b2_done_drop", 32'(bus.done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_sub_16
